// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared definitions for the DMEM arbiter: owner-register
//                encodings and the default starvation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Debug cycles a request may be denied before it is forced through.
    localparam int unsigned c_STARVE_LIMIT_DEFAULT = 8;

    // Which requester owned the DMEM port last cycle, and the access type.
    // This decides where the read data returning this cycle is routed.
    typedef enum logic [2:0] {
        OWN_IDLE    = 3'd0,
        OWN_PIPE_RD = 3'd1,
        OWN_PIPE_WR = 3'd2,
        OWN_DBG_RD  = 3'd3,
        OWN_DBG_WR  = 3'd4
    } owner_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear.
//                Clear takes priority over increment; the count holds once it
//                reaches the limit.
//  Ports       : clock, reset (sync, active-low), inc, clr,
//                limit [WIDTH-1:0], count [WIDTH-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q < limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Arbitrates a single-port data memory between the pipeline
//                MEM stage (normal priority) and a debug/loader port. The
//                debug port is served whenever the pipe is idle, and is forced
//                through after STARVE_LIMIT consecutive denied cycles.
//  Ports       : clock, reset (sync, active-low)
//                pipe_*   : MEM stage load/store request, stall, load data
//                dbg_req_*: debug request (valid/ready), dbg_rsp_*: read data
//                dmem_*   : single-port DMEM, read data one cycle after address
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_WIDTH  = 12,
    parameter int unsigned DMEM_WORD_WIDTH  = 16,
    parameter int unsigned STARVE_LIMIT     = c_STARVE_LIMIT_DEFAULT,
    parameter int unsigned STARVE_CNT_WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pipe_load,
    input  logic                       pipe_store,
    input  logic [DMEM_ADDR_WIDTH-1:0] pipe_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] pipe_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] pipe_wr_word,
    output logic                       pipe_stall,
    output logic [DMEM_WORD_WIDTH-1:0] pipe_rd_word,
    input  logic                       dbg_req_valid,
    input  logic                       dbg_req_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] dbg_req_word,
    output logic                       dbg_req_ready,
    output logic                       dbg_rsp_valid,
    output logic [DMEM_WORD_WIDTH-1:0] dbg_rsp_word,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] dmem_wr_word,
    output logic                       dmem_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] dmem_rd_word
);

    localparam logic [STARVE_CNT_WIDTH-1:0] c_LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    logic                        w_pipe_active;
    logic                        w_force;
    logic                        w_dbg_grant;
    logic                        w_pipe_grant;
    logic [STARVE_CNT_WIDTH-1:0] w_starve_cnt;
    owner_t                      owner_q;
    owner_t                      owner_d;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    assign w_pipe_active = pipe_load | pipe_store;
    assign w_force       = (w_starve_cnt == c_LIMIT);
    assign w_dbg_grant   = dbg_req_valid & (~w_pipe_active | w_force);
    assign w_pipe_grant  = w_pipe_active & ~w_dbg_grant;

    assign dbg_req_ready = w_dbg_grant;
    assign pipe_stall    = w_pipe_active & w_dbg_grant;

    // Counts consecutive denied debug cycles; any grant or a dropped request
    // restarts it, so after a forced grant the pipe again gets full priority.
    sat_counter #(
        .WIDTH (STARVE_CNT_WIDTH)
    ) u_starve_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (dbg_req_valid & ~w_dbg_grant),
        .clr   (w_dbg_grant | ~dbg_req_valid),
        .limit (c_LIMIT),
        .count (w_starve_cnt)
    );

    // ------------------------------------------------------------------
    // DMEM port mux and next owner
    // ------------------------------------------------------------------
    always_comb begin
        dmem_addr     = '0;
        dmem_wr_word  = '0;
        dmem_write_en = 1'b0;
        owner_d       = OWN_IDLE;
        if (w_dbg_grant) begin
            dmem_addr     = dbg_req_addr;
            dmem_wr_word  = dbg_req_word;
            dmem_write_en = dbg_req_we;
            owner_d       = dbg_req_we ? OWN_DBG_WR : OWN_DBG_RD;
        end else if (w_pipe_grant) begin
            // Store wins over a simultaneous load; the load is dropped.
            dmem_addr     = pipe_store ? pipe_wr_addr : pipe_rd_addr;
            dmem_wr_word  = pipe_wr_word;
            dmem_write_en = pipe_store;
            owner_d       = pipe_store ? OWN_PIPE_WR : OWN_PIPE_RD;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_q <= OWN_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Read-data routing. Gated by reset so a read captured just before
    // reset asserts never produces a response while reset is held.
    // ------------------------------------------------------------------
    assign dbg_rsp_valid = reset && (owner_q == OWN_DBG_RD);
    assign dbg_rsp_word  = dbg_rsp_valid ? dmem_rd_word : '0;
    assign pipe_rd_word  = (reset && (owner_q == OWN_PIPE_RD)) ? dmem_rd_word : '0;

endmodule : dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameters DMEM_ADDR_WIDTH default 12 (DMEM address bits), DMEM_WORD_WIDTH default 16 (DMEM data bits), STARVE_LIMIT default 8 (denied debug cycles before a forced grant) and STARVE_CNT_WIDTH default 4 (starvation counter bits).
REQ-002 The module SHALL use one clock and a synchronous, active-low reset; all state is sampled on the rising edge of clock.
REQ-003 The ports SHALL be:
  clock  in  1  system clock
  reset  in  1  synchronous active-low reset
  pipe_load  in  1  MEM stage load request
  pipe_store  in  1  MEM stage store request
  pipe_rd_addr  in  DMEM_ADDR_WIDTH  MEM stage load address
  pipe_wr_addr  in  DMEM_ADDR_WIDTH  MEM stage store address
  pipe_wr_word  in  DMEM_WORD_WIDTH  MEM stage store data
  pipe_stall  out  1  MEM stage must hold its request this cycle
  pipe_rd_word  out  DMEM_WORD_WIDTH  load data returned to MEM stage
  dbg_req_valid  in  1  debug/loader request valid
  dbg_req_we  in  1  debug request is a write
  dbg_req_addr  in  DMEM_ADDR_WIDTH  debug address
  dbg_req_word  in  DMEM_WORD_WIDTH  debug write data
  dbg_req_ready  out  1  debug request accepted this cycle
  dbg_rsp_valid  out  1  debug read data valid
  dbg_rsp_word  out  DMEM_WORD_WIDTH  debug read data
  dmem_addr  out  DMEM_ADDR_WIDTH  single-port DMEM address
  dmem_wr_word  out  DMEM_WORD_WIDTH  DMEM write data
  dmem_write_en  out  1  DMEM write enable
  dmem_rd_word  in  DMEM_WORD_WIDTH  DMEM read data, valid one cycle after address

Function
REQ-004 pipe_active SHALL be pipe_load OR pipe_store; when both are set, the store SHALL win and the load SHALL be ignored.
REQ-005 force SHALL be asserted when starve_cnt equals STARVE_LIMIT.
REQ-006 dbg_grant SHALL be dbg_req_valid AND (NOT pipe_active OR force); pipe_grant SHALL be pipe_active AND NOT dbg_grant.
REQ-007 dbg_req_ready SHALL equal dbg_grant (combinational); a request transfers when valid and ready are both high.
REQ-008 pipe_stall SHALL equal pipe_active AND dbg_grant; the MEM stage holds its inputs when pipe_stall is set.
REQ-009 On pipe_grant, the DMEM outputs SHALL be driven as follows: dmem_addr = pipe_wr_addr if store, else pipe_rd_addr; dmem_wr_word = pipe_wr_word; dmem_write_en = pipe_store.
REQ-010 On dbg_grant, the DMEM outputs SHALL be driven as follows: dmem_addr = dbg_req_addr; dmem_wr_word = dbg_req_word; dmem_write_en = dbg_req_we.
REQ-011 With no grant, dmem_addr, dmem_wr_word and dmem_write_en SHALL be 0.
REQ-012 The owner register SHALL have states IDLE, PIPE_RD, PIPE_WR, DBG_RD and DBG_WR, loaded each cycle from that cycle's grant and access type (IDLE when there is no grant).
REQ-013 dbg_rsp_valid SHALL be 1 exactly in the cycle after a debug read grant (owner = DBG_RD), and dbg_rsp_word SHALL then equal dmem_rd_word; otherwise both SHALL be 0.
REQ-014 pipe_rd_word SHALL equal dmem_rd_word when owner = PIPE_RD, and 0 otherwise.
REQ-015 starve_cnt update rules:
  - increments by 1 when dbg_req_valid and not dbg_grant;
  - saturates at STARVE_LIMIT;
  - clears to 0 on any dbg_grant or when dbg_req_valid is low.
REQ-016 Back-to-back debug requests while the pipe is idle SHALL be granted every cycle, with read latency of 1 cycle per request.
REQ-017 After a forced grant, the counter SHALL restart from 0, so the pipe regains priority for at least STARVE_LIMIT cycles.

Reset
REQ-018 While reset is low at a clock edge, the owner register SHALL become IDLE and starve_cnt SHALL become 0.
REQ-019 During reset and in the first cycle after it, dbg_rsp_valid, dbg_rsp_word and pipe_rd_word SHALL be 0; a debug read pending when reset was applied SHALL be dropped with no response.
REQ-020 Combinational outputs SHALL follow REQ-006 to REQ-011 during reset; the requesters are responsible for keeping requests deasserted.

Structure
REQ-021 The owner-state encodings and the STARVE_LIMIT default SHALL reside in the shared package dmem_arb_pkg.
REQ-022 The starvation counter SHALL be one sub-module, sat_counter, with inc, clr and saturation-limit inputs.

Verification
REQ-023 Pipe-only test: pipe_load, rd_addr 0x010, DMEM[0x010]=0xBEEF -> dmem_addr 0x010, pipe_rd_word 0xBEEF next cycle, dbg_rsp_valid 0.
REQ-024 Idle-pipe debug write test: dbg write 0x020 <- 0x1234 -> dbg_req_ready 1 and dmem_write_en 1 the same cycle; a following dbg read of 0x020 gives dbg_rsp_valid 1 and 0x1234 one cycle later.
REQ-025 Starvation test: pipe_load held continuously with dbg_req_valid high -> dbg_req_ready low for 8 cycles; in cycle 9 dbg_req_ready=1 and pipe_stall=1; in cycle 10 pipe is granted again and starve_cnt=0.
REQ-026 Simultaneous load+store test: pipe_load and pipe_store both high, wr_addr 0x030, rd_addr 0x040 -> dmem_addr 0x030, dmem_write_en 1, pipe_rd_word 0 next cycle.
REQ-027 Reset mid-read test: dbg read granted, reset low the next edge -> dbg_rsp_valid 0, owner IDLE, starve_cnt 0.
